// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for MIPS DIV/DIVU.
//
// Takes the two register-file operands (rs -> opa, rt -> opb). It produces the
// quotient (to LO) and the remainder (to HI). One quotient bit is resolved per
// clock cycle.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        divide request, sampled only while idle
//   signed_div   1 = DIV (two's complement), 0 = DIVU, sampled with start
//   opa, opb     dividend / divisor, sampled with start
//   cancel       pipeline flush, aborts an operation in flight
//   busy         high while in BUSY or FIXUP
//   done         one-cycle pulse, results valid in that cycle
//   quotient     quotient, held until the next completed operation
//   remainder    remainder, held until the next completed operation
//   div_by_zero  valid with done, set when the latched divisor was zero
//
// Handshake: start is a request that is accepted on a rising edge only when
// the unit is idle and cancel is low. No queueing is done, so a start seen
// while busy=1 or done=1 is dropped. The requester waits for done, which is a
// single-cycle pulse. The results stay stable after done until the next
// FIXUP.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] dvd_q;      // dividend shifting out, quotient bits shifting in
   logic [WIDTH-1:0] dvs_q;      // divisor magnitude
   logic [WIDTH-1:0] rem_q;      // partial remainder
   logic [CNT_W-1:0] cnt_q;
   logic             sign_q;
   logic             sign_r;
   logic             zero_q;

   // Operand preprocessing for the accepting edge.
   logic             neg_a, neg_b, opb_zero;
   logic [WIDTH-1:0] abs_a, abs_b;

   always_comb begin
      neg_a    = signed_div & opa[WIDTH-1];
      neg_b    = signed_div & opb[WIDTH-1];
      abs_a    = neg_a ? (-opa) : opa;
      abs_b    = neg_b ? (-opb) : opb;
      opb_zero = (opb == '0);
   end

   // One restoring step. The partial remainder is always below the divisor,
   // so a WIDTH+1-bit trial subtract is wide enough and its MSB is the borrow.
   logic [WIDTH:0] shifted, trial;
   logic           trial_neg;

   always_comb begin
      shifted   = {rem_q, dvd_q[WIDTH-1]};
      trial     = shifted - {1'b0, dvs_q};
      trial_neg = trial[WIDTH];
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and status outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start && !cancel) state_nxt = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (cancel)                                state_nxt = IDLE;
            else if (zero_q || cnt_q == CNT_W'(1))     state_nxt = FIXUP;
         end
         FIXUP: begin
            busy = 1'b1;
            if (cancel) state_nxt = IDLE;
            else        state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         zero_q      <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !cancel) begin
                  // A zero divisor keeps the raw dividend so that it can be
                  // returned untouched as the remainder.
                  dvd_q       <= opb_zero ? opa : abs_a;
                  dvs_q       <= abs_b;
                  rem_q       <= '0;
                  cnt_q       <= CNT_W'(WIDTH);
                  sign_q      <= neg_a ^ neg_b;
                  sign_r      <= neg_a;
                  zero_q      <= opb_zero;
                  div_by_zero <= 1'b0;
               end
            end
            BUSY: begin
               if (!cancel && !zero_q) begin
                  rem_q <= trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                  dvd_q <= {dvd_q[WIDTH-2:0], ~trial_neg};
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            FIXUP: begin
               if (!cancel) begin
                  if (zero_q) begin
                     quotient    <= '1;
                     remainder   <= dvd_q;
                     div_by_zero <= 1'b1;
                  end else begin
                     // Signed overflow (most negative / -1) wraps back to
                     // the most negative value through truncation.
                     quotient  <= sign_q ? (-dvd_q) : dvd_q;
                     remainder <= sign_r ? (-rem_q) : rem_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  localparam int W  = 32;
  localparam int TO = 60;

  logic         clk = 1'b0;
  logic         rst, start, signed_div, cancel;
  logic [W-1:0] opa, opb;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp  = 0;
  int n_fail = 0;

  // Each expected entry is {div_by_zero, quotient, remainder}.
  logic [2*W:0] exp_q[$];
  bit           prev_done = 1'b0;

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opa(opa), .opb(opb), .cancel(cancel), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model based on the architectural definition of DIV/DIVU.
  function automatic logic [2*W:0] model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q64, r64;
    logic [W-1:0] q, r;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    if (!sg) begin
      q = a / b;
      r = a % b;
      return {1'b0, q, r};
    end
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    q64 = sa / sb;
    r64 = sa % sb;
    q   = q64[W-1:0];
    r   = r64[W-1:0];
    return {1'b0, q, r};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (!rst && done) begin
      check("done_expected", 65'(exp_q.size() != 0), 65'd1);
      check("done_single_cycle", 65'(prev_done), 65'd0);
      check("busy_low_in_done", 65'(busy), 65'd0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_result", {div_by_zero, quotient, remainder}, e);
      end
    end
    prev_done = done;
  end

  // Driver: issue one divide, then wait for done. lat is the cycle number
  // in which done is observed, counting the cycle right after the start edge
  // as cycle 1. bcnt is the number of cycles in which busy was high.
  task automatic run_op(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit mid_pulse, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; signed_div = sg; opa = a; opb = b;
    exp_q.push_back(model(sg, a, b));
    @(negedge clk);
    start = 1'b0; signed_div = 1'($urandom_range(0, 1)); opa = $urandom; opb = $urandom;
    lat = 1; bcnt = 0;
    while (!done && lat < TO) begin
      bcnt += int'(busy);
      start = (mid_pulse && lat == 5);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      check("done_timeout", 65'(done), 65'd1);
      exp_q.delete();
    end
  endtask

  task automatic watch_no_done(input int cycles, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen |= done;
    end
    check(name, 65'(seen), 65'd0);
  endtask

  initial begin
    int lat, bcnt, cyc;
    logic [W-1:0] a, b;
    bit sg;

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; cancel = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, div_by_zero, quotient[W-2:0], remainder}, '0);
    check("reset_q_msb", 65'(quotient[W-1]), 65'd0);
    rst = 1'b0;

    // Model pins
    check("model_pin_divu", model(0, 32'd100, 32'd7), {1'b0, 32'd14, 32'd2});
    check("model_pin_div", model(1, 32'hFFFFFFF9, 32'd2), {1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF});
    check("model_pin_ovf", model(1, 32'h80000000, 32'hFFFFFFFF), {1'b0, 32'h80000000, 32'h0});

    // Basic unsigned: latency and busy width
    run_op(0, 32'd100, 32'd7, 0, lat, bcnt);
    check("divu_latency", 65'(lat), 65'd34);
    check("divu_busy_cycles", 65'(bcnt), 65'd33);
    check("divu_100_7", {div_by_zero, quotient, remainder}, {1'b0, 32'd14, 32'd2});

    // Signed sign handling
    run_op(1, 32'hFFFFFFF9, 32'd2, 0, lat, bcnt);
    check("div_m7_2", {div_by_zero, quotient, remainder}, {1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF});
    run_op(1, 32'd7, 32'hFFFFFFFE, 0, lat, bcnt);
    check("div_7_m2", {div_by_zero, quotient, remainder}, {1'b0, 32'hFFFFFFFD, 32'd1});

    // Overflow corner, signed and unsigned
    run_op(1, 32'h80000000, 32'hFFFFFFFF, 0, lat, bcnt);
    check("div_overflow", {div_by_zero, quotient, remainder}, {1'b0, 32'h80000000, 32'h0});
    run_op(0, 32'h80000000, 32'hFFFFFFFF, 0, lat, bcnt);
    check("divu_big", {div_by_zero, quotient, remainder}, {1'b0, 32'h0, 32'h80000000});

    // Divide by zero, then a normal op clears the flag
    run_op(0, 32'd5, 32'd0, 0, lat, bcnt);
    check("dbz_latency", 65'(lat), 65'd3);
    check("dbz_busy_cycles", 65'(bcnt), 65'd2);
    check("dbz_result", {div_by_zero, quotient, remainder}, {1'b1, 32'hFFFFFFFF, 32'd5});
    run_op(1, 32'hFFFFFFFB, 32'd0, 0, lat, bcnt);
    check("dbz_signed_raw_opa", {div_by_zero, quotient, remainder}, {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB});
    run_op(0, 32'd9, 32'd3, 0, lat, bcnt);
    check("after_dbz_9_3", {div_by_zero, quotient, remainder}, {1'b0, 32'd3, 32'd0});

    // start with cancel in IDLE: cancel wins
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; opa = 32'd40; opb = 32'd4;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel_busy", 65'(busy), 65'd0);
    watch_no_done(5, "idle_cancel_no_done");

    // Cancel in the middle of an operation
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd10;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy_low", 65'(busy), 65'd0);
    watch_no_done(40, "cancel_no_done");
    check("cancel_results_held", {quotient, remainder}, {1'b0, 32'd3, 32'd0});

    // Start pulse in mid operation must be ignored
    run_op(0, 32'd50, 32'd8, 1, lat, bcnt);
    check("mid_start_latency", 65'(lat), 65'd34);
    check("mid_start_50_8", {div_by_zero, quotient, remainder}, {1'b0, 32'd6, 32'd2});
    watch_no_done(40, "mid_start_no_extra_done");

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opa = 32'h12345678; opb = 32'h11;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_outputs", {busy, done, div_by_zero, quotient[W-2:0], remainder}, '0);
    check("midreset_q_msb", 65'(quotient[W-1]), 65'd0);
    watch_no_done(40, "midreset_no_done");
    run_op(0, 32'hFFFFFFFF, 32'h10, 0, lat, bcnt);
    check("after_reset_op", {div_by_zero, quotient, remainder}, {1'b0, 32'h0FFFFFFF, 32'hF});

    // Randomised operations against the model
    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 32'h80000000;
        1:       a = $urandom_range(0, 100);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = 32'hFFFFFFFF;
        2, 3:    b = $urandom_range(1, 20);
        4:       b = -($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(sg, a, b, 1'($urandom_range(0, 1)), lat, bcnt);
      check("rand_latency", 65'(lat), (b == '0) ? 65'd3 : 65'd34);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 65'(exp_q.size()), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
